// File: rtl/fir_sample_serializer_pkg.sv
// Shared constants and types for the FIR sample serializer.
package fir_sample_serializer_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef logic [DATA_WIDTH-1:0] sample_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Index of the oldest word, which is replayed first.
    localparam idx_t LAST_IDX = idx_t'(NUM_REGS - 1);

endpackage

// File: rtl/ser_block_buffer.sv
// Block capture register with an indexed read port.
module ser_block_buffer
    import fir_sample_serializer_pkg::*;
(
    input  logic                  clk,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i [0:NUM_REGS-1],
    input  logic [IDX_WIDTH-1:0]  rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    sample_t buf_q [0:NUM_REGS-1];

    // Capture the whole block on load; contents are don't-care otherwise, so no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                buf_q[i] <= data_i[i];
            end
        end
    end

    assign rd_data_o = buf_q[rd_idx_i];

endmodule

// File: rtl/fir_sample_serializer.sv
// Parallel-in, serial-out block replayer: emits buf[NUM_REGS-1] down to buf[0]
// on a valid/ready stream, accepting the next block on the final word's handshake.
module fir_sample_serializer
    import fir_sample_serializer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pDataIn [0:NUM_REGS-1],
    input  logic                  pValid,
    output logic                  pReady,
    output logic [DATA_WIDTH-1:0] serialDataOut,
    output logic                  sValid,
    input  logic                  sReady,
    output logic                  sLast,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  blockCount
);

    state_e               state_q, state_d;
    idx_t                 idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    sample_t              rd_data;

    logic idx_zero;
    logic word_fire;
    logic block_done;
    logic accept;

    assign idx_zero   = (idx_q == '0);
    assign word_fire  = (state_q == SHIFT) && sReady;
    assign block_done = word_fire && idx_zero;
    assign accept     = pValid && pReady;

    ser_block_buffer u_buf (
        .clk       (clk),
        .load_i    (accept),
        .data_i    (pDataIn),
        .rd_idx_i  (idx_q),
        .rd_data_o (rd_data)
    );

    // State, word index and completed-block counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, index and counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (block_done) begin
                    state_d = accept ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            idx_d = LAST_IDX;
        end else if (word_fire && !idx_zero) begin
            idx_d = idx_q - idx_t'(1);
        end

        if (block_done) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Outputs decoded from registered state; pReady also looks at sReady for zero-bubble reload.
    always_comb begin
        sValid        = 1'b0;
        busy          = 1'b0;
        sLast         = 1'b0;
        serialDataOut = '0;
        pReady        = 1'b0;
        blockCount    = cnt_q;

        if (state_q == SHIFT) begin
            sValid        = 1'b1;
            busy          = 1'b1;
            sLast         = idx_zero;
            serialDataOut = rd_data;
        end

        if (!rst) begin
            pReady = (state_q == IDLE) || block_done;
        end
    end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_fir_sample_serializer;
    import fir_sample_serializer_pkg::*;

    localparam int unsigned CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    sample_t         p_data [0:NUM_REGS-1];
    logic            pValid;
    logic            pReady;
    sample_t         serialDataOut;
    logic            sValid;
    logic            sReady;
    logic            sLast;
    logic            busy;
    logic [CW-1:0]   blockCount;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    // Reference: words still owed to the consumer, oldest at the front.
    sample_t       mq[$];
    logic [CW-1:0] mcnt;

    // Log of words actually handed to the consumer.
    int      log_cyc[$];
    sample_t log_dat[$];
    bit      log_last[$];

    fir_sample_serializer #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pDataIn       (p_data),
        .pValid        (pValid),
        .pReady        (pReady),
        .serialDataOut (serialDataOut),
        .sValid        (sValid),
        .sReady        (sReady),
        .sLast         (sLast),
        .busy          (busy),
        .blockCount    (blockCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        nchecks++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block(input int base);
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            p_data[i] = sample_t'(base + int'(NUM_REGS) - i);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            p_data[i] = sample_t'($urandom);
        end
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_dat.delete();
        log_last.delete();
    endtask

    // Wait (bounded) for the block on pDataIn to be taken; returns just after that edge.
    task automatic wait_accept(output int acc_cyc);
        bit ok;
        ok      = 1'b0;
        acc_cyc = -1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (pReady) begin
                acc_cyc = cyc;
                ok      = 1'b1;
                step();
                pValid = 1'b0;
            end
        end
        if (!ok) begin
            nchecks++;
            nerr++;
            $display("FAIL accept_timeout: got no pReady expected acceptance within 100 cycles");
            pValid = 1'b0;
        end
    endtask

    // Stream must be first, first+1, ... with sLast on multiples of NUM_REGS.
    task automatic chk_log(input string nm, input int n, input int first, input int span);
        chk({nm, "_len"}, log_dat.size(), n);
        for (int k = 0; k < n && k < log_dat.size(); k++) begin
            chk({nm, "_word"}, log_dat[k], first + k);
            chk({nm, "_last"}, log_last[k], ((first + k) % int'(NUM_REGS)) == 0);
        end
        if (log_dat.size() == n && n > 0) begin
            chk({nm, "_span"}, log_cyc[n-1] - log_cyc[0] + 1, span);
        end
    endtask

    initial begin
        int a1;
        int a2;

        rst    = 1'b1;
        pValid = 1'b1;
        sReady = 1'b1;
        set_block(0);

        // Reference model update on each active edge.
        fork
            begin : model
                int sz;
                bit prdy;
                forever begin
                    @(posedge clk);
                    if (rst) begin
                        mq.delete();
                        mcnt = '0;
                    end else begin
                        sz   = mq.size();
                        prdy = (sz == 0) || (sz == 1 && sReady);
                        if (sz > 0 && sReady) begin
                            void'(mq.pop_front());
                            if (sz == 1) mcnt = mcnt + CW'(1);
                        end
                        if (pValid && prdy) begin
                            for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
                                mq.push_back(p_data[i]);
                            end
                        end
                    end
                end
            end
        join_none

        step();

        // Compare every cycle, mid-period, against the model.
        fork
            begin : compare
                bit ev;
                forever begin
                    @(negedge clk);
                    cyc++;
                    ev = (mq.size() > 0);
                    chk("sValid", sValid, ev);
                    chk("busy", busy, ev);
                    chk("blockCount", blockCount, mcnt);
                    chk("pReady", pReady, !rst && (mq.size() == 0 || (mq.size() == 1 && sReady)));
                    if (ev) begin
                        chk("serialDataOut", serialDataOut, mq[0]);
                        chk("sLast", sLast, mq.size() == 1);
                    end
                    if (sValid && sReady && !rst) begin
                        log_cyc.push_back(cyc);
                        log_dat.push_back(serialDataOut);
                        log_last.push_back(sLast);
                    end
                end
            end
        join_none

        // Reset held two edges with pValid high.
        @(negedge clk);
        #1;
        chk("reset_pReady", pReady, 0);
        step();
        rst    = 1'b0;
        pValid = 1'b0;
        @(negedge clk);
        #1;
        chk("post_reset_sValid", sValid, 0);
        chk("post_reset_data", serialDataOut, 0);
        chk("post_reset_count", blockCount, 0);
        chk("post_reset_pReady", pReady, 1);
        chk("post_reset_busy", busy, 0);
        step();

        // Single block at full rate.
        clear_log();
        set_block(0);
        pValid = 1'b1;
        wait_accept(a1);
        repeat (10) step();
        chk_log("single", 8, 1, 8);
        if (log_cyc.size() > 0) chk("single_latency", log_cyc[0], a1 + 1);
        chk("single_count", blockCount, 1);
        chk("single_busy", busy, 0);

        // Backpressure on word 3 for three cycles.
        clear_log();
        set_block(0);
        pValid = 1'b1;
        wait_accept(a1);
        step();
        step();
        sReady = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_hold_data", serialDataOut, 3);
        chk("bp_hold_valid", sValid, 1);
        repeat (3) step();
        sReady = 1'b1;
        repeat (10) step();
        chk_log("bp", 8, 1, 11);
        chk("bp_count", blockCount, 2);

        // Back-to-back blocks with no bubble.
        clear_log();
        set_block(0);
        pValid = 1'b1;
        wait_accept(a1);
        set_block(8);
        pValid = 1'b1;
        wait_accept(a2);
        repeat (12) step();
        chk_log("b2b", 16, 1, 16);
        if (log_cyc.size() == 16) begin
            chk("b2b_latency", log_cyc[0], a1 + 1);
            chk("b2b_accept_on_last", a2, log_cyc[7]);
        end
        chk("b2b_count", blockCount, 4);

        // Offer a new block while busy, wiggling pDataIn before it settles.
        clear_log();
        set_block(0);
        pValid = 1'b1;
        wait_accept(a1);
        step();
        pValid = 1'b1;
        scramble();
        @(negedge clk);
        #1;
        chk("busy_pReady_low", pReady, 0);
        step();
        scramble();
        step();
        set_block(8);
        wait_accept(a2);
        repeat (12) step();
        chk_log("busy", 16, 1, 16);
        if (log_cyc.size() == 16) begin
            chk("busy_latency", log_cyc[0], a1 + 1);
            chk("busy_accept_on_last", a2, log_cyc[7]);
        end
        chk("busy_count", blockCount, 6);

        // Reset after three words have gone out.
        clear_log();
        set_block(0);
        pValid = 1'b1;
        wait_accept(a1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_sValid", sValid, 0);
        chk("rst_mid_sLast", sLast, 0);
        chk("rst_mid_count", blockCount, 0);
        chk_log("rst_mid", 3, 1, 3);
        step();
        clear_log();
        set_block(8);
        pValid = 1'b1;
        wait_accept(a1);
        repeat (10) step();
        chk_log("after_rst", 8, 9, 8);
        chk("after_rst_count", blockCount, 1);

        // Counter wrap: 14 more blocks reach the maximum, one more wraps to zero.
        for (int b = 0; b < 14; b++) begin
            set_block(0);
            pValid = 1'b1;
            wait_accept(a1);
        end
        repeat (10) step();
        chk("wrap_max", blockCount, 15);
        set_block(0);
        pValid = 1'b1;
        wait_accept(a1);
        repeat (10) step();
        chk("wrap_zero", blockCount, 0);

        // Random traffic with occasional resets.
        repeat (3000) begin
            sReady = ($urandom_range(0, 3) != 0);
            pValid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) scramble();
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst    = 1'b0;
        pValid = 1'b0;
        sReady = 1'b1;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
